rtc_core: RTL and testbench
===========================

# rtc_core

Parametrised time-of-day counter: successor to the basic clock block. Adds a cycle prescaler, run/pause, validated time load, 12/24-hour display mode and an optional alarm comparator. Sits between the system clock and the seven-segment/display driver and supplies packed-BCD hours, minutes and seconds.

## Interface
- CLK_PER_SEC, 50000000: clk cycles per second; must be ≥ 2. Prescaler width is $clog2(CLK_PER_SEC).
- clk  in  1  system clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- run  in  1  1 = time advances; 0 = prescaler and time frozen.
- mode12  in  1  display mode: 0 = 24-hour, 1 = 12-hour. Internal time is always 24-hour.
- set_valid  in  1  load request, sampled every cycle.
- set_h  in  5  binary hour 0–23.
- set_m, set_s  in  6 each  binary minute/second 0–59.
- set_err  out  1  one-cycle pulse: load rejected.
- alarm_valid  in  1  write alarm registers (RTC_ALARM_EN only).
- alarm_h  in  5, alarm_m  in  6  binary alarm time.
- alarm_ack  in  1  clears alarm_pending.
- h, m, s  out  8 each  packed BCD, tens in [7:4], units in [3:0].
- pm  out  1  1 when internal hour ≥ 12 and mode12 = 1; else 0.
- sec_tick  out  1  one-cycle pulse on each second increment.
- alarm_hit  out  1  one-cycle pulse on alarm match.
- alarm_pending  out  1  sticky flag, set by alarm_hit.

## Operation
- State: prescaler pre (0..CLK_PER_SEC-1); binary sec, min (0–59), hr (0–23).
- Reset: pre = sec = min = hr = 0. Outputs h = m = s = 8'h00, pm = 0, sec_tick = set_err = alarm_hit = alarm_pending = 0. Alarm registers reset to 00:00, alarm disarmed.
- Counting when run = 1 and no accepted load: pre increments; at pre == CLK_PER_SEC-1, pre → 0 and a second tick occurs.
- On tick: sec 59→0 carries to min; min 59→0 carries to hr; hr 23→0. sec is never 60, min is never 60, hr is never 24.
- Load: set_valid = 1 with set_h ≤ 23, set_m ≤ 59 and set_s ≤ 59 is accepted. Fields are written, pre → 0, and no tick occurs that cycle. Load has priority over a coincident tick.
- Out-of-range load: time is unchanged, counting continues normally, and set_err pulses on the next cycle.
- run = 0: pre holds. Loads are still accepted.
- Display in 24-hour mode: h = BCD(hr).
- Display in 12-hour mode: hr 0 → 12; hr 1–12 → same value; hr 13–23 → hr-12. pm = (hr ≥ 12).
- BCD conversion is combinational from registered binary. Division and modulo by 10 on ≤ 6-bit values are allowed.
- Alarm: alarm_valid writes the alarm registers and arms the alarm. Out-of-range values are rejected via set_err and leave the alarm disarmed.
- Alarm match: on a tick whose new time is alarm_h:alarm_m:00, alarm_hit pulses and alarm_pending sets.
- Load landing on the alarm time does not fire the alarm.
- alarm_ack clears alarm_pending. If ack and hit coincide, set wins.

## Timing
- Registered time updates on the clock edge where pre == CLK_PER_SEC-1 and run = 1.
- sec_tick is high during the cycle after that edge, concurrent with the new h/m/s values.
- Load: new values visible the cycle after set_valid is sampled. The first subsequent tick arrives exactly CLK_PER_SEC cycles later when run = 1.
- set_err and alarm_hit are single-cycle and registered (latency 1).
- mode12 is combinational to h and pm, with 0 cycles of latency.
- resetn assertion is asynchronous. It takes effect mid-count or mid-load, with no partial update. Deassertion must be synchronised externally.

## Configuration
- RTC_ALARM_EN defined: alarm registers, comparator, alarm_hit and alarm_pending are built. alarm_valid and alarm_ack are functional.
- RTC_ALARM_EN undefined: alarm logic is removed, alarm_hit and alarm_pending are tied to 0, and alarm_valid and alarm_ack are ignored. All other behaviour is identical.

## Test plan
- Reset then run = 1, CLK_PER_SEC = 4: sec_tick every 4 cycles. After 240 cycles, m = 8'h01 and s = 8'h00.
- Load 23:59:58, then 2 ticks: h = 8'h00, m = 8'h00, s = 8'h00. No intermediate value of 60 or 24 ever appears.
- Load 24:00:00 or 12:60:00: set_err pulses 1 cycle and time is unchanged. A valid load coincident with a tick yields the loaded value, and the next tick comes 4 cycles later.
- mode12 = 1 at hr 0, 12 and 13: h = 8'h12/pm = 0, h = 8'h12/pm = 1, h = 8'h01/pm = 1.
- RTC_ALARM_EN, alarm 00:01, start 00:00:58: alarm_hit pulses once on the transition to 00:01:00 and pending stays 1 until alarm_ack. Simultaneous hit and ack leaves pending = 1.
- Assert resetn low mid-second with run = 1: all outputs are 0 immediately. After release, the first tick arrives CLK_PER_SEC cycles later.

Source files
------------

// File: rtl/rtc_core.sv
// Time-of-day counter: prescaled seconds, validated load, 12/24h BCD display.
// Define RTC_ALARM_EN to build the hour:minute alarm comparator.
module rtc_core #(
  parameter int CLK_PER_SEC = 50000000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       run,
  input  logic       mode12,
  input  logic       set_valid,
  input  logic [4:0] set_h,
  input  logic [5:0] set_m,
  input  logic [5:0] set_s,
  output logic       set_err,
  input  logic       alarm_valid,
  input  logic [4:0] alarm_h,
  input  logic [5:0] alarm_m,
  input  logic       alarm_ack,
  output logic [7:0] h,
  output logic [7:0] m,
  output logic [7:0] s,
  output logic       pm,
  output logic       sec_tick,
  output logic       alarm_hit,
  output logic       alarm_pending
);

  localparam int PW = (CLK_PER_SEC > 2) ? $clog2(CLK_PER_SEC) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(CLK_PER_SEC - 1);

  logic [PW-1:0] pre;
  logic [5:0]    sec;
  logic [5:0]    min;
  logic [4:0]    hr;

  logic          load_ok;
  logic          load_bad;
  logic          wrap;
  logic          tick;
  logic          alarm_bad;
  logic          sec_wrap;
  logic          min_wrap;
  logic [5:0]    sec_n;
  logic [5:0]    min_n;
  logic [4:0]    hr_n;

  assign load_ok  = set_valid && (set_h <= 5'd23)
                 && (set_m <= 6'd59) && (set_s <= 6'd59);
  assign load_bad = set_valid && !load_ok;
  assign wrap     = (pre == PRE_MAX);
  // A coincident accepted load swallows the tick.
  assign tick     = run && !load_ok && wrap;

  assign sec_wrap = (sec == 6'd59);
  assign min_wrap = (min == 6'd59);

  always_comb begin
    sec_n = sec_wrap ? 6'd0 : sec + 6'd1;
    min_n = min;
    hr_n  = hr;
    if (sec_wrap) begin
      min_n = min_wrap ? 6'd0 : min + 6'd1;
      if (min_wrap) begin
        hr_n = (hr == 5'd23) ? 5'd0 : hr + 5'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pre      <= '0;
      sec      <= '0;
      min      <= '0;
      hr       <= '0;
      sec_tick <= 1'b0;
      set_err  <= 1'b0;
    end else begin
      sec_tick <= tick;
      set_err  <= load_bad || alarm_bad;
      if (load_ok) begin
        pre <= '0;
        sec <= set_s;
        min <= set_m;
        hr  <= set_h;
      end else if (run) begin
        pre <= wrap ? '0 : pre + 1'b1;
        if (wrap) begin
          sec <= sec_n;
          min <= min_n;
          hr  <= hr_n;
        end
      end
    end
  end

`ifdef RTC_ALARM_EN
  logic       armed;
  logic [4:0] al_h;
  logic [5:0] al_m;
  logic       match;

  assign alarm_bad = alarm_valid
                  && ((alarm_h > 5'd23) || (alarm_m > 6'd59));
  // New time is hh:mm:00 exactly when the old seconds were 59.
  assign match = tick && armed && sec_wrap
              && (min_n == al_m) && (hr_n == al_h);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      armed         <= 1'b0;
      al_h          <= '0;
      al_m          <= '0;
      alarm_hit     <= 1'b0;
      alarm_pending <= 1'b0;
    end else begin
      if (alarm_valid) begin
        al_h  <= alarm_h;
        al_m  <= alarm_m;
        armed <= !alarm_bad;
      end
      alarm_hit     <= match;
      alarm_pending <= match || alarm_hit
                    || (alarm_pending && !alarm_ack);
    end
  end
`else
  logic unused_alarm;

  assign alarm_bad     = 1'b0;
  assign alarm_hit     = 1'b0;
  assign alarm_pending = 1'b0;
  assign unused_alarm  = ^{alarm_valid, alarm_h, alarm_m, alarm_ack};
`endif

  function automatic logic [7:0] bcd(input logic [5:0] v);
    return {4'(v / 6'd10), 4'(v % 6'd10)};
  endfunction

  logic [4:0] hr12;
  logic [4:0] hr_disp;

  always_comb begin
    if (hr == 5'd0) hr12 = 5'd12;
    else if (hr > 5'd12) hr12 = hr - 5'd12;
    else hr12 = hr;
  end

  assign hr_disp = mode12 ? hr12 : hr;
  assign pm      = mode12 && (hr >= 5'd12);
  assign h       = bcd({1'b0, hr_disp});
  assign m       = bcd(min);
  assign s       = bcd(sec);

endmodule

// File: tb/tb_rtc_core.sv
// Directed plus randomized bench for rtc_core with a seconds-of-day model.
// Alarm checks are compiled in when RTC_ALARM_EN is defined.
module tb_rtc_core;

  localparam int CPS = 4;

  logic       clk = 1'b0;
  logic       resetn;
  logic       run;
  logic       mode12;
  logic       set_valid;
  logic [4:0] set_h;
  logic [5:0] set_m;
  logic [5:0] set_s;
  logic       set_err;
  logic       alarm_valid;
  logic [4:0] alarm_h;
  logic [5:0] alarm_m;
  logic       alarm_ack;
  logic [7:0] h;
  logic [7:0] m;
  logic [7:0] s;
  logic       pm;
  logic       sec_tick;
  logic       alarm_hit;
  logic       alarm_pending;

  rtc_core #(.CLK_PER_SEC(CPS)) dut (
    .clk(clk), .resetn(resetn), .run(run), .mode12(mode12),
    .set_valid(set_valid), .set_h(set_h), .set_m(set_m),
    .set_s(set_s), .set_err(set_err), .alarm_valid(alarm_valid),
    .alarm_h(alarm_h), .alarm_m(alarm_m), .alarm_ack(alarm_ack),
    .h(h), .m(m), .s(s), .pm(pm), .sec_tick(sec_tick),
    .alarm_hit(alarm_hit), .alarm_pending(alarm_pending)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: time as seconds since midnight.
  int tod;
  int pre_m;
  int a_min;
  bit armed;
  bit e_tick;
  bit e_err;
  bit e_hit;
  bit e_pend;

  function automatic logic [7:0] bcd(input int v);
    return 8'(((v / 10) << 4) + (v % 10));
  endfunction

  task automatic model_reset();
    tod = 0; pre_m = 0; a_min = 0; armed = 0;
    e_tick = 0; e_err = 0; e_hit = 0; e_pend = 0;
  endtask

  task automatic model_edge();
    bit ok, tk, abad, hit;
    int nt;
    if (!resetn) begin
      model_reset();
      return;
    end
    ok = set_valid && set_h <= 23 && set_m <= 59 && set_s <= 59;
    tk = run && !ok && pre_m == CPS - 1;
    nt = ok ? int'(set_h) * 3600 + int'(set_m) * 60 + int'(set_s)
       : tk ? (tod + 1) % 86400 : tod;
    abad = 0;
    hit = 0;
`ifdef RTC_ALARM_EN
    abad = alarm_valid && (alarm_h > 23 || alarm_m > 59);
    hit = tk && armed && nt == a_min * 60;
    e_pend = hit || e_hit || (e_pend && !alarm_ack);
    if (alarm_valid) begin
      armed = !abad;
      a_min = int'(alarm_h) * 60 + int'(alarm_m);
    end
`endif
    e_hit = hit;
    e_err = (set_valid && !ok) || abad;
    e_tick = tk;
    pre_m = ok ? 0 : run ? (pre_m + 1) % CPS : pre_m;
    tod = nt;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int hr, hd;
    hr = tod / 3600;
    hd = mode12 ? ((hr + 11) % 12) + 1 : hr;
    chk("h", h, bcd(hd));
    chk("m", m, bcd((tod / 60) % 60));
    chk("s", s, bcd(tod % 60));
    chk("pm", {7'd0, pm}, {7'd0, mode12 && hr >= 12});
    chk("sec_tick", {7'd0, sec_tick}, {7'd0, e_tick});
    chk("set_err", {7'd0, set_err}, {7'd0, e_err});
    chk("alarm_hit", {7'd0, alarm_hit}, {7'd0, e_hit});
    chk("alarm_pending", {7'd0, alarm_pending}, {7'd0, e_pend});
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic load(input int hh, input int mm, input int ss);
    set_valid = 1;
    set_h = 5'(hh); set_m = 6'(mm); set_s = 6'(ss);
    step();
    set_valid = 0;
  endtask

  initial begin
    int ticks;
    int hits;
    resetn = 0; run = 0; mode12 = 0; set_valid = 0;
    set_h = 0; set_m = 0; set_s = 0;
    alarm_valid = 0; alarm_h = 0; alarm_m = 0; alarm_ack = 0;
    model_reset();
    #1;
    chk("reset_h", h, 8'h00);
    chk("reset_s", s, 8'h00);
    check_all();
    step();
    step();
    resetn = 1;
    run = 1;

    // 240 cycles is one minute at four cycles per second.
    ticks = 0;
    for (int i = 0; i < 240; i++) begin
      step();
      if (sec_tick) ticks++;
    end
    chk("ticks_240", 8'(ticks), 8'd60);
    chk("m_240", m, 8'h01);
    chk("s_240", s, 8'h00);

    load(23, 59, 58);
    chk("load_h", h, 8'h23);
    chk("load_s", s, 8'h58);
    for (int i = 0; i < 8; i++) step();
    chk("wrap_h", h, 8'h00);
    chk("wrap_m", m, 8'h00);
    chk("wrap_s", s, 8'h00);

    load(24, 0, 0);
    chk("bad_h_err", {7'd0, set_err}, 8'd1);
    step();
    chk("bad_h_err_clr", {7'd0, set_err}, 8'd0);
    load(12, 60, 0);
    chk("bad_m_err", {7'd0, set_err}, 8'd1);
    step();

    for (int i = 0; i < CPS && pre_m != CPS - 1; i++) step();
    load(5, 6, 7);
    chk("coinc_s", s, 8'h07);
    chk("coinc_tick", {7'd0, sec_tick}, 8'd0);
    for (int i = 0; i < CPS - 1; i++) step();
    chk("coinc_notick", {7'd0, sec_tick}, 8'd0);
    step();
    chk("coinc_tick4", {7'd0, sec_tick}, 8'd1);
    chk("coinc_s4", s, 8'h08);

    run = 0;
    load(0, 0, 0);
    mode12 = 1;
    #1;
    check_all();
    chk("m12_h0", h, 8'h12);
    chk("m12_pm0", {7'd0, pm}, 8'd0);
    load(12, 0, 0);
    chk("m12_h12", h, 8'h12);
    chk("m12_pm12", {7'd0, pm}, 8'd1);
    load(13, 0, 0);
    chk("m12_h13", h, 8'h01);
    chk("m12_pm13", {7'd0, pm}, 8'd1);
    mode12 = 0;
    #1;
    check_all();

`ifdef RTC_ALARM_EN
    alarm_valid = 1; alarm_h = 0; alarm_m = 1;
    step();
    alarm_valid = 0;
    run = 1;
    load(0, 0, 58);
    hits = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (alarm_hit) hits++;
    end
    chk("alarm_hits", 8'(hits), 8'd1);
    chk("alarm_pend", {7'd0, alarm_pending}, 8'd1);
    alarm_ack = 1;
    step();
    alarm_ack = 0;
    chk("alarm_ack", {7'd0, alarm_pending}, 8'd0);
    load(0, 0, 59);
    alarm_ack = 1;
    for (int i = 0; i < CPS; i++) step();
    chk("ack_hit_same", {7'd0, alarm_pending}, 8'd1);
    chk("ack_hit_pulse", {7'd0, alarm_hit}, 8'd1);
    alarm_ack = 0;
    step();
    alarm_valid = 1; alarm_h = 24; alarm_m = 0;
    step();
    alarm_valid = 0;
    chk("alarm_bad_err", {7'd0, set_err}, 8'd1);
`else
    hits = 0;
`endif

    for (int i = 0; i < 1500; i++) begin
      run = ($urandom_range(0, 3) != 0);
      mode12 = 1'($urandom);
      set_valid = ($urandom_range(0, 19) == 0);
      set_h = 5'($urandom_range(0, 25));
      set_m = 6'($urandom_range(0, 63));
      set_s = 6'($urandom_range(55, 63));
      alarm_valid = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 1) == 1) begin
        alarm_h = 5'(((tod / 60 + 1) % 1440) / 60);
        alarm_m = 6'((tod / 60 + 1) % 60);
      end else begin
        alarm_h = 5'($urandom_range(0, 31));
        alarm_m = 6'($urandom_range(0, 63));
      end
      alarm_ack = ($urandom_range(0, 9) == 0);
      step();
    end
    run = 1; mode12 = 0; set_valid = 0;
    alarm_valid = 0; alarm_ack = 0;

    for (int i = 0; i < CPS && pre_m != 2; i++) step();
    #2;
    resetn = 0;
    model_reset();
    #1;
    chk("areset_s", s, 8'h00);
    chk("areset_h", h, 8'h00);
    check_all();
    step();
    resetn = 1;
    for (int i = 0; i < CPS - 1; i++) step();
    chk("rel_notick", {7'd0, sec_tick}, 8'd0);
    step();
    chk("rel_tick", {7'd0, sec_tick}, 8'd1);
    chk("rel_s", s, 8'h01);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
